vote_round_ctrl: RTL and testbench

Sequencer for a three-voter majority decision. It opens a voting round on request and collects one ballot from each of three voters through per-voter valid/ack handshakes. It closes the round when all ballots are in or a timeout expires, then presents the majority result through a valid/ready output handshake. It sits between the voter sources and any consumer of the 2-of-3 decision, and owns the combinational majority cell.

---
 rtl/vote_pkg.sv | 20 ++
 rtl/vote_maj3.sv | 16 +
 rtl/vote_round_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_vote_round_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vote_pkg.sv
// -----------------------------------------------------------------------------
// vote_pkg
// Shared types and constants for the three-voter round controller.
//   state_t    : round sequencer states (IDLE, COLLECT, DONE)
//   N_VOTERS   : number of voters, and therefore the voter-vector width
//   vote_vec_t : one bit per voter (valid, ack, ballot, got mask)
// -----------------------------------------------------------------------------
package vote_pkg;

    localparam int N_VOTERS = 3;

    typedef logic [N_VOTERS-1:0] vote_vec_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        COLLECT = 2'b01,
        DONE    = 2'b10
    } state_t;

endpackage : vote_pkg

// File: rtl/vote_maj3.sv
// -----------------------------------------------------------------------------
// vote_maj3
// Purely combinational 2-of-3 majority cell.
//   a, b, c : input bits
//   y       : 1 when at least two of a, b, c are 1
// -----------------------------------------------------------------------------
module vote_maj3 (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);

    assign y = (a & b) | (b & c) | (c & a);

endmodule : vote_maj3

// File: rtl/vote_round_ctrl.sv
// -----------------------------------------------------------------------------
// vote_round_ctrl
// Opens a voting round on request, collects one ballot from each of three
// voters through per-voter valid/ack handshakes, closes the round when every
// ballot is in or the collection timer expires, and presents the 2-of-3
// decision through a valid/ready handshake.
//
// Parameters
//   TIMEOUT : maximum number of COLLECT cycles per round (2..65535)
//   CNT_W   : width of the completed-round counter
//
// Ports
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   start       : open a round (sampled in IDLE only)
//   vote_valid  : per-voter ballot present, held until acked
//   vote_val    : per-voter ballot value, stable while valid
//   vote_ack    : per-voter ballot accepted this cycle (combinational)
//   busy        : round in progress (COLLECT or DONE)
//   res_valid   : result available (DONE)
//   res_ready   : consumer accepts the result
//   res_out     : majority of received ballots, missing ballots count as 0
//   res_timeout : round closed with fewer than three ballots
//   res_mask    : which ballots were received
//   round_cnt   : completed rounds, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module vote_round_ctrl
    import vote_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       vote_valid,
    input  logic [2:0]       vote_val,
    output logic [2:0]       vote_ack,
    output logic             busy,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_out,
    output logic             res_timeout,
    output logic [2:0]       res_mask,
    output logic [CNT_W-1:0] round_cnt
);

    // The timer only has to reach TIMEOUT-1: the FSM leaves COLLECT there.
    localparam int              TMR_W    = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t            state_q;
    state_t            state_d;
    vote_vec_t         got_q;
    vote_vec_t         ballot_q;
    logic [TMR_W-1:0]  timer_q;
    logic [CNT_W-1:0]  round_cnt_q;

    logic              start_round;
    logic              close_round;
    logic              result_taken;
    logic              in_done;
    logic              maj_y;

    // -------------------------------------------------------------------------
    // Next-state and handshake decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        state_d      = state_q;
        vote_ack     = '0;
        start_round  = 1'b0;
        close_round  = 1'b0;
        result_taken = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = COLLECT;
                    start_round = 1'b1;
                end
            end

            COLLECT: begin
                // A voter already accepted this round is not acked again.
                vote_ack = vote_valid & ~got_q;
                // Ballots acked in the closing cycle still count, hence the
                // OR with this cycle's acks.
                if (((got_q | vote_ack) == 3'b111) || (timer_q == TMR_LAST)) begin
                    state_d     = DONE;
                    close_round = 1'b1;
                end
            end

            DONE: begin
                if (res_ready) begin
                    state_d      = IDLE;
                    result_taken = 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of process ordering.
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Ballot, got mask, collection timer and round counter
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            got_q       <= '0;
            ballot_q    <= '0;
            timer_q     <= '0;
            round_cnt_q <= '0;
        end else begin
            if (start_round) begin
                got_q    <= '0;
                ballot_q <= '0;
                timer_q  <= '0;
            end else if (state_q == COLLECT) begin
                got_q    <= got_q | vote_ack;
                ballot_q <= (ballot_q & ~vote_ack) | (vote_val & vote_ack);
                // Hold the timer on the closing cycle so it never wraps.
                if (!close_round) begin
                    timer_q <= timer_q + 1'b1;
                end
            end

            if (result_taken) begin
                round_cnt_q <= round_cnt_q + 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Majority of received ballots; missing ballots are masked to 0
    // -------------------------------------------------------------------------
    vote_maj3 u_maj (
        .a (ballot_q[0] & got_q[0]),
        .b (ballot_q[1] & got_q[1]),
        .c (ballot_q[2] & got_q[2]),
        .y (maj_y)
    );

    // -------------------------------------------------------------------------
    // Outputs: decoded from registers only, so res_ready never reaches them
    // combinationally. Result fields read 0 outside DONE.
    // -------------------------------------------------------------------------
    assign in_done     = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign res_valid   = in_done;
    assign res_out     = in_done & maj_y;
    assign res_mask    = in_done ? got_q : 3'b000;
    assign res_timeout = in_done & (got_q != 3'b111);
    assign round_cnt   = round_cnt_q;

    // -------------------------------------------------------------------------
    // Design invariants
    // -------------------------------------------------------------------------
    a_ack_only_in_collect : assert property (
        @(posedge clk) disable iff (!rst_n)
        (state_q != COLLECT) |-> (vote_ack == 3'b000)
    );

    a_timer_bounded : assert property (
        @(posedge clk) disable iff (!rst_n)
        (timer_q <= TMR_LAST)
    );

endmodule : vote_round_ctrl

// File: tb/tb_vote_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_vote_round_ctrl
// Self-checking bench for vote_round_ctrl. Each round's expected result is
// computed from the stimulus and pushed to a scoreboard queue; a monitor pops
// and compares it when the result handshake completes. A small round counter
// width makes the counter wrap within a short run.
// -----------------------------------------------------------------------------
module tb_vote_round_ctrl;

    localparam int TB_TIMEOUT = 6;
    localparam int TB_CNT_W   = 3;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [2:0]          vote_valid;
    logic [2:0]          vote_val;
    logic [2:0]          vote_ack;
    logic                busy;
    logic                res_valid;
    logic                res_ready;
    logic                res_out;
    logic                res_timeout;
    logic [2:0]          res_mask;
    logic [TB_CNT_W-1:0] round_cnt;

    typedef struct {
        logic                out;
        logic                timeout;
        logic [2:0]          mask;
        logic [TB_CNT_W-1:0] cnt;
    } exp_t;

    exp_t                sb[$];
    int                  n_checks  = 0;
    int                  n_fail    = 0;
    logic [TB_CNT_W-1:0] model_cnt = '0;

    always #5 clk = ~clk;

    vote_round_ctrl #(
        .TIMEOUT (TB_TIMEOUT),
        .CNT_W   (TB_CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .vote_valid  (vote_valid),
        .vote_val    (vote_val),
        .vote_ack    (vote_ack),
        .busy        (busy),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_out     (res_out),
        .res_timeout (res_timeout),
        .res_mask    (res_mask),
        .round_cnt   (round_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compare on the accepting cycle, away from the edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && res_valid && res_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", sb.size(), 1);
            end else begin
                e = sb.pop_front();
                check("sb_res_out",     res_out,     e.out);
                check("sb_res_timeout", res_timeout, e.timeout);
                check("sb_res_mask",    res_mask,    e.mask);
                check("sb_round_cnt",   round_cnt,   e.cnt);
            end
        end
    end

    // One complete round. t0..t2: cycle (after start) at which voter i first
    // raises valid, 0 = never. hold0: cycles voter 0 keeps valid high.
    // wait_cyc: DONE cycles with res_ready low (start pulsed meanwhile).
    task automatic run_round(input logic [2:0] vals, input int t0, input int t1,
                             input int t2, input int hold0, input int wait_cyc,
                             input string name);
        int         t[3];
        int         close_cyc;
        int         n_ones;
        int         acks[3];
        logic       all_in;
        logic [2:0] mask;
        logic [2:0] got;
        exp_t       e;

        t = '{t0, t1, t2};
        all_in    = 1'b1;
        close_cyc = 0;
        for (int i = 0; i < 3; i++) begin
            if (t[i] < 1 || t[i] > TB_TIMEOUT) all_in = 1'b0;
            else if (t[i] > close_cyc)          close_cyc = t[i];
        end
        if (!all_in) close_cyc = TB_TIMEOUT;

        n_ones = 0;
        for (int i = 0; i < 3; i++) begin
            mask[i] = (t[i] >= 1) && (t[i] <= close_cyc);
            if (mask[i] && vals[i]) n_ones++;
        end
        e.out     = (n_ones >= 2);
        e.timeout = (mask != 3'b111);
        e.mask    = mask;
        e.cnt     = model_cnt;
        sb.push_back(e);

        // cycle 0: request the round
        start = 1'b1;
        step();
        start = 1'b0;

        got  = 3'b000;
        acks = '{0, 0, 0};
        for (int cyc = 1; cyc <= close_cyc; cyc++) begin
            logic [2:0] v;
            for (int i = 0; i < 3; i++) begin
                v[i] = (t[i] >= 1) && (cyc >= t[i]) && (cyc < t[i] + ((i == 0) ? hold0 : 1));
            end
            vote_valid = v;
            vote_val   = vals;
            #1;
            check({name, ":ack"},       vote_ack,  v & ~got);
            check({name, ":busy"},      busy,      1);
            check({name, ":early_res"}, res_valid, 0);
            got = got | v;
            for (int i = 0; i < 3; i++) if (vote_ack[i]) acks[i]++;
            step();
        end
        vote_valid = 3'b000;

        for (int i = 0; i < 3; i++) check({name, ":ack_count"}, acks[i], mask[i]);

        // DONE with backpressure; start pulses must be ignored
        for (int k = 0; k < wait_cyc; k++) begin
            res_ready = 1'b0;
            start     = (k % 2 == 1);
            #1;
            check({name, ":hold_valid"}, res_valid,   1);
            check({name, ":hold_mask"},  res_mask,    e.mask);
            check({name, ":hold_out"},   res_out,     e.out);
            check({name, ":hold_to"},    res_timeout, e.timeout);
            check({name, ":hold_ack"},   vote_ack,    0);
            step();
        end
        start     = 1'b0;
        res_ready = 1'b1;
        #1;
        check({name, ":res_valid"}, res_valid, 1);
        check({name, ":res_mask"},  res_mask,  e.mask);
        step();
        res_ready = 1'b0;
        model_cnt = model_cnt + 1'b1;
        #1;
        check({name, ":idle_busy"},  busy,      0);
        check({name, ":idle_valid"}, res_valid, 0);
        check({name, ":idle_mask"},  res_mask,  0);
        check({name, ":round_cnt"},  round_cnt, model_cnt);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        vote_valid = 3'b000;
        vote_val   = 3'b000;
        res_ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack",       vote_ack,    0);
        check("rst_busy",      busy,        0);
        check("rst_res_valid", res_valid,   0);
        check("rst_res_out",   res_out,     0);
        check("rst_res_to",    res_timeout, 0);
        check("rst_res_mask",  res_mask,    0);
        check("rst_round_cnt", round_cnt,   0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        run_round(3'b110, 1, 1, 1, 1, 0, "full");
        run_round(3'b001, 1, 5, 3, 1, 0, "stagger");
        run_round(3'b010, 0, 2, 0, 1, 0, "timeout");
        run_round(3'b011, 1, 1, 2, 1, 10, "backpressure");
        run_round(3'b101, 1, 0, TB_TIMEOUT, 3, 0, "dup_close");
        for (int r = 0; r < 4; r++) begin
            run_round(3'($urandom_range(0, 7)),
                      int'($urandom_range(0, TB_TIMEOUT + 1)),
                      int'($urandom_range(0, TB_TIMEOUT + 1)),
                      int'($urandom_range(0, TB_TIMEOUT + 1)),
                      int'($urandom_range(1, 3)),
                      int'($urandom_range(0, 2)),
                      "random");
        end

        // Reset in COLLECT after two ballots were accepted
        start = 1'b1;
        step();
        start      = 1'b0;
        vote_val   = 3'b011;
        vote_valid = 3'b001;
        step();
        vote_valid = 3'b010;
        step();
        vote_valid = 3'b100;
        #1;
        check("pre_rst_ack", vote_ack, 3'b100);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ack",       vote_ack,    0);
        check("mid_rst_busy",      busy,        0);
        check("mid_rst_res_valid", res_valid,   0);
        check("mid_rst_res_out",   res_out,     0);
        check("mid_rst_res_to",    res_timeout, 0);
        check("mid_rst_res_mask",  res_mask,    0);
        check("mid_rst_round_cnt", round_cnt,   0);
        vote_valid = 3'b000;
        model_cnt  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        run_round(3'b111, 0, 0, 0, 1, 0, "after_rst");

        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_vote_round_ctrl
